// File: rtl/chunked_subtractor.sv
// rtl/chunked_subtractor.sv - multi-cycle chunked subtractor recovering an addend from a sum
//
// Purpose:
//   Computes r = sum - in1 over WIDTH+1 bits, CHUNK bits per clock, LSB first.
//   The borrow is carried between chunks in a register. The recovered addend
//   appears on diff, together with underflow/overflow flags.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   start      in   1        request; sampled only in IDLE or DONE
//   sum        in   WIDTH+1  minuend, captured on accepted start
//   in1        in   WIDTH    subtrahend, captured on accepted start
//   busy       out  1        high while in CALC
//   done       out  1        one-cycle pulse, result valid
//   diff       out  WIDTH    recovered addend, held until the next result
//   underflow  out  1        sum < in1
//   overflow   out  1        sum - in1 > 2^WIDTH-1
//
// Configuration:
//   SUB_SATURATE_EN  when defined, diff saturates to 0 on underflow and to
//                    all-ones on overflow; otherwise diff wraps modulo 2^WIDTH.

module chunked_subtractor #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             underflow,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
    $error("chunked_subtractor: WIDTH must be a multiple of CHUNK");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH:0]   sum_q;
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic [IDXW-1:0]  idx;

  // Datapath operands for the chunk processed on this edge.
  logic             first;
  logic             do_step;
  logic [WIDTH:0]   op_sum;
  logic [WIDTH-1:0] op_in1;
  logic             b_in;
  logic [IDXW-1:0]  cur_idx;
  logic [CHUNK:0]   chunk_d;
  logic             bout;
  logic             last;
  logic [WIDTH-1:0] res_next;
  logic             uf_next;
  logic             of_next;
  logic [WIDTH-1:0] diff_next;

  assign busy = (state == ST_CALC);
  assign done = (state == ST_DONE);

  // A start accepted in DONE processes chunk 0 straight from the input ports
  // on the accepting edge, so back-to-back results come every NCHUNK cycles.
  assign first   = (state == ST_DONE) && start;
  assign do_step = (state == ST_CALC) || first;

  always_comb begin
    op_sum  = first ? sum : sum_q;
    op_in1  = first ? in1 : in1_q;
    b_in    = first ? 1'b0 : borrow;
    cur_idx = first ? '0 : idx;

    chunk_d = {1'b0, op_sum[cur_idx*CHUNK +: CHUNK]}
            - {1'b0, op_in1[cur_idx*CHUNK +: CHUNK]}
            - {{CHUNK{1'b0}}, b_in};
    bout    = chunk_d[CHUNK];
    last    = (cur_idx == IDXW'(NCHUNK - 1));

    res_next = first ? '0 : res;
    res_next[cur_idx*CHUNK +: CHUNK] = chunk_d[CHUNK-1:0];

    // Top bit t = sum[WIDTH] - borrow: borrowing out of it means sum < in1,
    // while a surviving 1 means the difference needs WIDTH+1 bits.
    uf_next = ~op_sum[WIDTH] & bout;
    of_next =  op_sum[WIDTH] & ~bout;

`ifdef SUB_SATURATE_EN
    if (uf_next) begin
      diff_next = '0;
    end else if (of_next) begin
      diff_next = {WIDTH{1'b1}};
    end else begin
      diff_next = res_next;
    end
`else
    diff_next = res_next;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sum_q     <= '0;
      in1_q     <= '0;
      res       <= '0;
      borrow    <= 1'b0;
      idx       <= '0;
      diff      <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sum_q  <= sum;
            in1_q  <= in1;
            res    <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            state  <= ST_CALC;
          end
        end
        ST_CALC, ST_DONE: begin
          if (do_step) begin
            if (first) begin
              sum_q <= sum;
              in1_q <= in1;
            end
            res    <= res_next;
            borrow <= bout;
            if (last) begin
              idx       <= '0;
              diff      <= diff_next;
              underflow <= uf_next;
              overflow  <= of_next;
              state     <= ST_DONE;
            end else begin
              idx   <= cur_idx + IDXW'(1);
              state <= ST_CALC;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_subtractor.sv
// tb/tb_chunked_subtractor.sv - directed scoreboard bench for chunked_subtractor

module tb_chunked_subtractor;

  localparam int WIDTH  = 8;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] in1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             underflow;
  logic             overflow;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             u;
    logic             o;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef SUB_SATURATE_EN
  localparam logic [WIDTH-1:0] D_UNDER = 8'd0;
  localparam logic [WIDTH-1:0] D_OVER  = 8'd255;
`else
  localparam logic [WIDTH-1:0] D_UNDER = 8'd226;
  localparam logic [WIDTH-1:0] D_OVER  = 8'd134;
`endif

  chunked_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sum       (sum),
    .in1       (in1),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .underflow (underflow),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic u, input logic o);
    exp_t e;
    e.d = d;
    e.u = u;
    e.o = o;
    sb.push_back(e);
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", 32'(diff), 32'(e.d));
        check("underflow", 32'(underflow), 32'(e.u));
        check("overflow", 32'(overflow), 32'(e.o));
      end
    end
  end

  // Wait (bounded) for done, checking busy/done each cycle; n counts edges from E0.
  task automatic wait_done(inout int n);
    while (!done && n < 20) begin
      check("busy_calc", 32'(busy), 32'd1);
      check("done_calc", 32'(done), 32'd0);
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [WIDTH:0] s, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] d, input logic u, input logic o);
    int n;
    sum = s; in1 = a; start = 1'b1;
    push(d, u, o);
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    wait_done(n);
    check("latency", 32'(n), 32'(NCHUNK + 1));
    check("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; sum = '0; in1 = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_uf", 32'(underflow), 32'd0);
    check("rst_of", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(9'd300, 8'd200, 8'd100, 1'b0, 1'b0);
    run_op(9'd256, 8'd1,   8'd255, 1'b0, 1'b0);
    run_op(9'd50,  8'd80,  D_UNDER, 1'b1, 1'b0);
    run_op(9'd400, 8'd10,  D_OVER,  1'b0, 1'b1);

    // Handshake: start and operand changes during CALC are ignored.
    sum = 9'd100; in1 = 8'd30; start = 1'b1;
    push(8'd70, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; sum = 9'd500; in1 = 8'd1;
    check("busy_e1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    n = 3;
    wait_done(n);
    check("latency_hs", 32'(n), 32'(NCHUNK + 1));

    // Start held in DONE: back-to-back second operation.
    sum = 9'd200; in1 = 8'd55; start = 1'b1;
    push(8'd145, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_drop", 32'(done), 32'd0);
    n = 1;
    wait_done(n);
    check("b2b_gap", 32'(n), 32'(NCHUNK));
    @(posedge clk); #1;
    check("b2b_idle", 32'(done), 32'd0);

    // Asynchronous reset mid-CALC after E2: outputs clear before the next edge.
    sum = 9'd200; in1 = 8'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_uf", 32'(underflow), 32'd0);
    check("arst_of", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (NCHUNK + 2) begin
      @(posedge clk); #1;
      check("no_done_after_rst", 32'(done), 32'd0);
    end

    run_op(9'd9, 8'd4, 8'd5, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
